rf_wb_arbiter: RTL and testbench
================================

// Module: rf_wb_arbiter
// PURPOSE
//  Shares the register file's single synchronous write port between two requesters: the in-order
//  pipeline writeback (priority) and the long-latency unit (divider/load miss, valid/ready).
//  The long-latency result waits in a one-entry hold buffer. A starvation counter eventually
//  stalls the pipeline so the held result can drain.
//  Sits between the WB stage / LL unit and reg_file's regwrite/write_reg/write_data port.
// PARAMETERS
//  DATA_W        32  register data width
//  ADDR_W        5   register index width (x0 = index 0)
//  STARVE_LIMIT  4   consecutive lost-arbitration cycles before the held entry is forced (>=1)
// PORTS
//  clock          in   1       rising-edge clock
//  reset          in   1       asynchronous, active-high
//  pipe_valid     in   1       pipeline WB write request this cycle
//  pipe_rd        in   ADDR_W  pipeline destination register
//  pipe_data      in   DATA_W  pipeline write data
//  pipe_stall     out  1       pipeline must hold WB (request not taken this cycle)
//  ll_valid       in   1       LL unit result valid
//  ll_ready       out  1       hold buffer can accept the LL result
//  ll_rd          in   ADDR_W  LL destination register
//  ll_data        in   DATA_W  LL result data
//  hold_valid     out  1       hold buffer occupied (decode uses this for RAW stall)
//  hold_rd        out  ADDR_W  destination register of the held entry
//  rf_regwrite    out  1       to reg_file regwrite
//  rf_write_reg   out  ADDR_W  to reg_file write_reg
//  rf_write_data  out  DATA_W  to reg_file write_data
// BEHAVIOUR
//  - Reset (async): state=IDLE, hold empty, wait_cnt=0, ll_ready=1, pipe_stall=0,
//    hold_valid=0, hold_rd=0. rf_regwrite is forced 0 while reset is high.
//  - LL transfer occurs on ll_valid&&ll_ready. It is loaded into the hold buffer at the next edge,
//    except when ll_rd==0: the result is accepted and dropped (no load).
//  - ll_ready = hold empty, OR the held entry drains or is cancelled this cycle (back-to-back refill).
//  - Write port outputs are combinational and take effect in reg_file at the same edge.
//    Whenever the selected rd==0, rf_regwrite=0.
//  - FSM (2-bit): IDLE (hold empty), HOLD (hold full, waiting), FORCE (hold has priority).
//    IDLE:  pipe request passes straight through. LL accept -> HOLD with wait_cnt=0.
//    HOLD:  if !pipe_valid or pipe_rd==0, the held entry is written and the next state is IDLE
//           (or HOLD if refilled).
//           Otherwise the pipe wins and wait_cnt++. When wait_cnt reaches STARVE_LIMIT-1 while
//           blocked -> FORCE.
//    FORCE: pipe_stall=1 and the held entry is written. Next state is IDLE (or HOLD if refilled),
//           and wait_cnt=0.
//  - WAW: if the pipe wins and pipe_rd==hold_rd (nonzero), the held entry is cancelled (the pipe
//    value is newer). hold_valid drops at the next edge and no later write of the stale value occurs.
//  - The hold entry is never written and refilled with a different value in the same cycle without
//    the old one reaching the port first.
//  - pipe_stall is asserted only in FORCE. The pipeline is never stalled more than 1 cycle per held
//    entry.
//  - Worst-case LL latency from accept to reg_file write is STARVE_LIMIT+1 cycles.
//  - Reset mid-operation discards the held entry (no write).
// CONFIGURATION
//  RF_WB_BYPASS_EN defined: adds outputs byp_valid (1), byp_rd (ADDR_W), byp_data (DATA_W).
//    They equal rf_regwrite/rf_write_reg/rf_write_data this cycle, so decode can forward a value
//    being written in the same cycle as an async read of the same register.
//  RF_WB_BYPASS_EN undefined: these ports do not exist. Decode must stall one cycle on a same-cycle
//    match instead.
// STRUCTURE
//  - Shared include rf_defs.vh: RF_ADDR_W, RF_DATA_W, RF_X0 index, and the state encodings
//    ST_IDLE=2'd0, ST_HOLD=2'd1, ST_FORCE=2'd2.
//  - One sub-module, rf_wb_hold_buf: one-entry valid/rd/data register with load, drain and cancel
//    inputs.
//  - The FSM, wait counter and write-port mux stay in rf_wb_arbiter.
// TESTING
//  1. Reset asserted mid-HOLD (hold x7=0x55) -> hold_valid=0, ll_ready=1, and x7 is never written.
//  2. Pipe x3=0x11 only -> rf_regwrite=1, rf_write_reg=3, data 0x11 the same cycle, pipe_stall=0.
//  3. LL x5=0xAA accepted, pipe idle next cycle -> x5 written the cycle after accept, state IDLE.
//  4. LL x5 held, pipe writes x1,x2,x3,x4 consecutively (STARVE_LIMIT=4):
//     - the 4 pipe writes proceed;
//     - the next cycle pipe_stall=1 and x5=0xAA is written;
//     - the following cycle pipe_stall=0.
//  5. LL x9=0x1 held, pipe writes x9=0x2 -> hold cancelled, x9 ends 0x2, no later write of 0x1.
//  6. ll_rd=0 and pipe_rd=0 requests -> rf_regwrite stays 0, ll_ready stays 1, hold_valid stays 0.
//     With RF_WB_BYPASS_EN, byp_* track rf_* in every scenario above.

Source files
------------

// File: rtl/rf_wb_arbiter_pkg.sv
// rf_wb_arbiter_pkg: shared register-file widths, x0 index and arbiter state encodings
package rf_wb_arbiter_pkg;
  localparam int RF_ADDR_W = 5;
  localparam int RF_DATA_W = 32;
  localparam int RF_X0 = 0;
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_HOLD  = 2'd1,
    ST_FORCE = 2'd2
  } state_t;
endpackage

// File: rtl/rf_wb_arbiter_hold_buf.sv
// rf_wb_hold_buf: one-entry valid/rd/data buffer for the long-latency result
module rf_wb_hold_buf
  import rf_wb_arbiter_pkg::*;
#(
  parameter int ADDR_W = RF_ADDR_W,
  parameter int DATA_W = RF_DATA_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              load,
  input  logic              drain,
  input  logic              cancel,
  input  logic [ADDR_W-1:0] load_rd,
  input  logic [DATA_W-1:0] load_data,
  output logic              valid,
  output logic [ADDR_W-1:0] rd,
  output logic [DATA_W-1:0] data
);
  // a refill wins over drain/cancel so back-to-back entries never leave a bubble
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      valid <= 1'b0;
      rd    <= '0;
      data  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      rd    <= load_rd;
      data  <= load_data;
    end else if (drain || cancel) begin
      valid <= 1'b0;
    end
endmodule

// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter: shares the reg_file write port between pipeline WB and the long-latency unit (optional RF_WB_BYPASS_EN adds byp_* outputs)
module rf_wb_arbiter
  import rf_wb_arbiter_pkg::*;
#(
  parameter int DATA_W       = RF_DATA_W,
  parameter int ADDR_W       = RF_ADDR_W,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              pipe_valid,
  input  logic [ADDR_W-1:0] pipe_rd,
  input  logic [DATA_W-1:0] pipe_data,
  output logic              pipe_stall,
  input  logic              ll_valid,
  output logic              ll_ready,
  input  logic [ADDR_W-1:0] ll_rd,
  input  logic [DATA_W-1:0] ll_data,
  output logic              hold_valid,
  output logic [ADDR_W-1:0] hold_rd,
  output logic              rf_regwrite,
  output logic [ADDR_W-1:0] rf_write_reg,
`ifdef RF_WB_BYPASS_EN
  output logic              byp_valid,
  output logic [ADDR_W-1:0] byp_rd,
  output logic [DATA_W-1:0] byp_data,
`endif
  output logic [DATA_W-1:0] rf_write_data
);
  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [ADDR_W-1:0] X0 = ADDR_W'(RF_X0);
  localparam logic [CW-1:0] CNT_MAX = CW'(STARVE_LIMIT - 1);
  state_t state, next_state;
  logic [CW-1:0] wait_cnt, next_cnt;
  logic [DATA_W-1:0] hold_data;
  logic hold_sel, hold_cancel, ll_load;
  logic [ADDR_W-1:0] wr_rd;
  rf_wb_hold_buf #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_hold (
    .clock     (clock),
    .reset     (reset),
    .load      (ll_load),
    .drain     (hold_sel),
    .cancel    (hold_cancel),
    .load_rd   (ll_rd),
    .load_data (ll_data),
    .valid     (hold_valid),
    .rd        (hold_rd),
    .data      (hold_data)
  );
  // state and starvation counter registers
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      state    <= ST_IDLE;
      wait_cnt <= '0;
    end else begin
      state    <= next_state;
      wait_cnt <= next_cnt;
    end
  // next state: a drained/cancelled/forced entry returns to IDLE unless refilled in the same cycle
  always_comb begin
    next_state = state;
    next_cnt   = '0;
    case (state)
      ST_IDLE:  next_state = ll_load ? ST_HOLD : ST_IDLE;
      ST_HOLD:
        if (hold_sel || hold_cancel) next_state = ll_load ? ST_HOLD : ST_IDLE;
        else if (wait_cnt == CNT_MAX) next_state = ST_FORCE;
        else next_cnt = wait_cnt + 1'b1;
      ST_FORCE: next_state = ll_load ? ST_HOLD : ST_IDLE;
      default:  next_state = ST_IDLE;
    endcase
  end
  // outputs: hold entry takes the port when forced or when the pipe has nothing real to write
  always_comb begin
    hold_sel      = (state == ST_FORCE) || (state == ST_HOLD && (!pipe_valid || pipe_rd == X0));
    hold_cancel   = (state == ST_HOLD) && pipe_valid && pipe_rd != X0 && pipe_rd == hold_rd;
    ll_ready      = (state == ST_IDLE) || hold_sel || hold_cancel;
    ll_load       = ll_valid && ll_ready && ll_rd != X0;
    pipe_stall    = (state == ST_FORCE);
    wr_rd         = hold_sel ? hold_rd : pipe_rd;
    rf_write_reg  = wr_rd;
    rf_write_data = hold_sel ? hold_data : pipe_data;
    rf_regwrite   = !reset && (hold_sel || pipe_valid) && wr_rd != X0;
  end
`ifdef RF_WB_BYPASS_EN
  assign byp_valid = rf_regwrite;
  assign byp_rd    = rf_write_reg;
  assign byp_data  = rf_write_data;
`endif
endmodule

// File: tb/tb_rf_wb_arbiter.sv
// tb_rf_wb_arbiter: directed scenarios plus random traffic checked against a hold-entry reference model
module tb_rf_wb_arbiter;
  localparam int LIMIT = 4;
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic pipe_valid = 1'b0, ll_valid = 1'b0;
  logic [4:0] pipe_rd = '0, ll_rd = '0;
  logic [31:0] pipe_data = '0, ll_data = '0;
  logic pipe_stall, ll_ready, hold_valid, rf_regwrite;
  logic [4:0] hold_rd, rf_write_reg;
  logic [31:0] rf_write_data;
`ifdef RF_WB_BYPASS_EN
  logic byp_valid;
  logic [4:0] byp_rd;
  logic [31:0] byp_data;
`endif
  int checks = 0, errors = 0;
  logic m_v = 1'b0;
  logic [4:0] m_rd = '0;
  logic [31:0] m_d = '0;
  int m_lost = 0;
  always #5 clock = ~clock;
  rf_wb_arbiter #(.DATA_W(32), .ADDR_W(5), .STARVE_LIMIT(LIMIT)) dut (
    .clock(clock), .reset(reset),
    .pipe_valid(pipe_valid), .pipe_rd(pipe_rd), .pipe_data(pipe_data), .pipe_stall(pipe_stall),
    .ll_valid(ll_valid), .ll_ready(ll_ready), .ll_rd(ll_rd), .ll_data(ll_data),
    .hold_valid(hold_valid), .hold_rd(hold_rd),
    .rf_regwrite(rf_regwrite), .rf_write_reg(rf_write_reg),
`ifdef RF_WB_BYPASS_EN
    .byp_valid(byp_valid), .byp_rd(byp_rd), .byp_data(byp_data),
`endif
    .rf_write_data(rf_write_data)
  );
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask
  task automatic reset_check(input string tag);
    chk({tag, " hold_valid"}, 64'(hold_valid), 64'd0);
    chk({tag, " ll_ready"}, 64'(ll_ready), 64'd1);
    chk({tag, " pipe_stall"}, 64'(pipe_stall), 64'd0);
    chk({tag, " regwrite"}, 64'(rf_regwrite), 64'd0);
    m_v = 1'b0;
    m_lost = 0;
  endtask
  task automatic cycle(input string tag, input logic pv, input logic [4:0] prd, input logic [31:0] pd,
                       input logic lv, input logic [4:0] lrd, input logic [31:0] ld);
    logic frc, hw, cnc, rdy, we;
    logic [4:0] wr;
    logic [31:0] wd;
    pipe_valid = pv; pipe_rd = prd; pipe_data = pd;
    ll_valid = lv; ll_rd = lrd; ll_data = ld;
    frc = m_v && m_lost == LIMIT;
    hw  = frc || (m_v && (!pv || prd == 0));
    cnc = m_v && !hw && pv && prd == m_rd;
    wr  = hw ? m_rd : prd;
    wd  = hw ? m_d : pd;
    we  = (hw || pv) && wr != 0;
    rdy = !m_v || hw || cnc;
    @(negedge clock);
    chk({tag, " regwrite"}, 64'(rf_regwrite), 64'(we));
    if (we) begin
      chk({tag, " write_reg"}, 64'(rf_write_reg), 64'(wr));
      chk({tag, " write_data"}, 64'(rf_write_data), 64'(wd));
    end
    chk({tag, " pipe_stall"}, 64'(pipe_stall), 64'(frc));
    chk({tag, " ll_ready"}, 64'(ll_ready), 64'(rdy));
    chk({tag, " hold_valid"}, 64'(hold_valid), 64'(m_v));
    if (m_v) chk({tag, " hold_rd"}, 64'(hold_rd), 64'(m_rd));
`ifdef RF_WB_BYPASS_EN
    chk({tag, " byp_valid"}, 64'(byp_valid), 64'(we));
    if (we) begin
      chk({tag, " byp_rd"}, 64'(byp_rd), 64'(wr));
      chk({tag, " byp_data"}, 64'(byp_data), 64'(wd));
    end
`endif
    @(posedge clock);
    if (lv && rdy && lrd != 0) begin
      m_v = 1'b1; m_rd = lrd; m_d = ld; m_lost = 0;
    end else if (hw || cnc) m_v = 1'b0;
    else if (m_v) m_lost++;
    #1;
  endtask
  initial begin
    pipe_valid = 1'b1; pipe_rd = 5'd3; pipe_data = 32'h11;
    repeat (2) @(posedge clock);
    #1;
    reset_check("reset");
    chk("reset hold_rd", 64'(hold_rd), 64'd0);
    reset = 1'b0;
    cycle("t1 accept", 0, 0, 0, 1, 5'd7, 32'h55);
    pipe_valid = 0; ll_valid = 0;
    #2 reset = 1'b1;
    #1 reset_check("t1 midreset");
    @(posedge clock);
    #1 reset = 1'b0;
    cycle("t1 after", 0, 0, 0, 0, 0, 0);
    cycle("t1 after2", 0, 0, 0, 0, 0, 0);
    cycle("t2 pipe", 1, 5'd3, 32'h11, 0, 0, 0);
    cycle("t3 accept", 0, 0, 0, 1, 5'd5, 32'hAA);
    cycle("t3 drain", 0, 0, 0, 0, 0, 0);
    cycle("t3 idle", 0, 0, 0, 0, 0, 0);
    cycle("t4 accept", 0, 0, 0, 1, 5'd5, 32'hAA);
    for (int i = 1; i <= 4; i++) cycle("t4 pipe", 1, 5'(i), 32'(i), 0, 0, 0);
    cycle("t4 force", 1, 5'd6, 32'h66, 0, 0, 0);
    cycle("t4 resume", 1, 5'd6, 32'h66, 0, 0, 0);
    cycle("t5 accept", 0, 0, 0, 1, 5'd9, 32'h1);
    cycle("t5 cancel", 1, 5'd9, 32'h2, 0, 0, 0);
    cycle("t5 after", 0, 0, 0, 0, 0, 0);
    cycle("t5 after2", 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) cycle("t6 x0", 1, 5'd0, 32'hDEAD, 1, 5'd0, 32'hBEEF);
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 99) == 0) begin
        reset = 1'b1;
        #1 reset_check("rand reset");
        @(posedge clock);
        #1 reset = 1'b0;
      end
      cycle("rand", $urandom_range(0, 9) < 6, 5'($urandom_range(0, 7)), $urandom,
            $urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)), $urandom);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
